// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial adder sequencer: feeds an external 4-bit adder one nibble per
// cycle, registers the carry between nibbles and presents the result with start/busy/done.
module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_s,
  input  logic             add_cout
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NIB - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [NIB-1:0][3:0]   a_q, a_d;
  logic [NIB-1:0][3:0]   b_q, b_d;
  logic [NIB-1:0][3:0]   acc_q, acc_d;
  logic [NIB-1:0][3:0]   sum_q, sum_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic                  carry_q, carry_d;
  logic                  cout_q, cout_d;
  logic                  ovf_q, ovf_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    add_a   = 4'h0;
    add_b   = 4'h0;
    add_cin = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          carry_d = cin;
          idx_d   = '0;
          acc_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        add_a         = a_q[idx_q];
        add_b         = b_q[idx_q];
        add_cin       = carry_q;
        acc_d[idx_q]  = add_s;
        carry_d       = add_cout;
        idx_d         = idx_q + IDXW'(1);
        // Results are published only here, so RUN never exposes partial sums.
        if (idx_q == LAST) begin
          state_d = S_DONE;
          sum_d   = acc_d;
          cout_d  = add_cout;
          ovf_d   = (a_q[NIB-1][3] == b_q[NIB-1][3]) &&
                    (acc_d[NIB-1][3] != a_q[NIB-1][3]);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl with a behavioural 4-bit adder attached.
module tb_nibble_serial_add_ctrl;
  logic        clk = 1'b0;
  logic        rst, start, cin;
  logic [15:0] op_a, op_b;
  logic        busy, done, cout, overflow;
  logic [15:0] sum;
  logic [3:0]  add_a, add_b, add_s;
  logic        add_cin, add_cout;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign {add_cout, add_s} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

  nibble_serial_add_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; start is accepted at the following posedge.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic c);
    start = 1'b1; op_a = a; op_b = b; cin = c;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; op_a = 16'hDEAD; op_b = 16'hBEEF; cin = 1'b0;
  endtask

  // Already one negedge past acceptance on entry; counts that as cycle 1.
  task automatic wait_done(input string tag, input logic [15:0] es, input logic ec,
                           input logic ev, input int pulse_at);
    int cyc = 1;
    int bcnt = 0;
    while (!done && cyc < 20) begin
      if (busy) bcnt++;
      if (cyc == pulse_at) begin
        start = 1'b1; op_a = 16'h1111; op_b = 16'h1111;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_lat"},  cyc, 5);
    chk({tag, "_busy"}, bcnt, 4);
    chk({tag, "_sum"},  sum, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_ovf"},  overflow, ev);
  endtask

  initial begin
    int dn;
    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out", {sum, cout, overflow}, 0);
    chk("rst_addif", {add_a, add_b, add_cin}, 0);
    @(negedge clk);

    start_op(16'h1234, 16'h1111, 1'b0);
    chk("t1_adda", add_a, 4'h4);
    wait_done("t1", 16'h2345, 1'b0, 1'b0, -1);
    chk("t1_busy_at_done", busy, 0);
    @(negedge clk);
    chk("t1_done_pulse", done, 0);
    chk("t1_idle_addif", {add_a, add_b, add_cin}, 0);

    start_op(16'hFFFF, 16'h0001, 1'b0);
    wait_done("t2", 16'h0000, 1'b1, 1'b0, -1);
    @(negedge clk);

    start_op(16'h7FFF, 16'h0001, 1'b0);
    wait_done("t3a", 16'h8000, 1'b0, 1'b1, -1);
    @(negedge clk);
    start_op(16'h8000, 16'h8000, 1'b0);
    wait_done("t3b", 16'h0000, 1'b1, 1'b1, -1);
    @(negedge clk);

    start_op(16'h0000, 16'h0000, 1'b1);
    wait_done("t4a", 16'h0001, 1'b0, 1'b0, -1);
    // Back-to-back: start raised in the DONE cycle itself.
    start_op(16'h00FF, 16'h0001, 1'b0);
    chk("t4_b2b_busy", busy, 1);
    wait_done("t4b", 16'h0100, 1'b0, 1'b0, -1);
    @(negedge clk);

    start_op(16'h4000, 16'h4000, 1'b0);
    wait_done("t5", 16'h8000, 1'b0, 1'b1, 2);
    dn = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("t5_extra_done", dn, 0);
    chk("t5_busy", busy, 0);
    chk("t5_hold", sum, 16'h8000);

    start_op(16'h5555, 16'h2222, 1'b0);
    chk("t6_run1", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_busy", busy, 0);
    chk("t6_out", {sum, cout, overflow}, 0);
    dn = 0;
    repeat (6) begin
      if (done) dn++;
      @(negedge clk);
    end
    chk("t6_no_done", dn, 0);
    start_op(16'hABCD, 16'h1234, 1'b0);
    wait_done("t6b", 16'hBE01, 1'b0, 1'b0, -1);
    @(negedge clk);
    start_op(16'h0F0F, 16'h00F1, 1'b1);
    wait_done("t6c", 16'h1001, 1'b0, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
